spi_tx: RTL

SPI_TX -- requirements
Module: spi_tx

---
 rtl/spi_tx_if.sv | 34 +++
 rtl/spi_tx.sv | 119 +++++++++++
 2 files changed

// File: rtl/spi_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_tx_if
//  Description : Handshake and serial-link bundle for spi_tx.
//                i_pdin  - parallel byte to transmit (sampled on load accept)
//                i_load  - one-cycle start strobe
//                o_sclk  - serial clock, idle low
//                o_mosi  - serial data, MSB first
//                o_stb   - latch strobe after the 8th bit
//                o_busy  - transfer in progress
//                o_done  - one-cycle completion pulse
//                Names carry the direction seen from the transmitter (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_tx_if;
    logic [7:0] i_pdin;
    logic       i_load;
    logic       o_sclk;
    logic       o_mosi;
    logic       o_stb;
    logic       o_busy;
    logic       o_done;

    modport master (
        output i_pdin, i_load,
        input  o_sclk, o_mosi, o_stb, o_busy, o_done
    );

    modport slave (
        input  i_pdin, i_load,
        output o_sclk, o_mosi, o_stb, o_busy, o_done
    );
endinterface
`default_nettype wire

// File: rtl/spi_tx.sv
`default_nettype none
// ============================================================================
//  Module      : spi_tx
//  Description : Byte-wide serial transmitter for the front-panel shift
//                register link. Sends i_pdin MSB first on o_mosi with o_sclk
//                (idle low, CLKDIV clk cycles per half period), then raises
//                o_stb for one half period so the far end latches the byte.
//  Ports       : clk  - system clock, rising edge
//                rst  - asynchronous active-high reset
//                bus  - spi_tx_if.slave (i_pdin, i_load, o_sclk, o_mosi,
//                       o_stb, o_busy, o_done)
//  Parameters  : CLKDIV - o_sclk half period in clk cycles, 1..255
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_tx #(
    parameter int CLKDIV = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    spi_tx_if.slave   bus
);

    localparam logic [7:0] C_HALF_LAST = 8'(CLKDIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOW   = 2'd1,
        S_HIGH  = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t     r_state;
    logic [7:0] r_sr;      // r_sr[7] is the bit currently on o_mosi
    logic [7:0] r_half;
    logic [2:0] r_bit;
    logic       r_sclk;
    logic       r_stb;
    logic       r_busy;
    logic       r_done;

    wire logic  w_half_end;
    assign w_half_end = (r_half == C_HALF_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sr    <= 8'h00;
            r_half  <= 8'd0;
            r_bit   <= 3'd0;
            r_sclk  <= 1'b0;
            r_stb   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_load) begin
                        r_sr    <= bus.i_pdin;
                        r_half  <= 8'd0;
                        r_bit   <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (w_half_end) begin
                        r_half  <= 8'd0;
                        r_sclk  <= 1'b1;
                        r_state <= S_HIGH;
                    end else begin
                        r_half <= r_half + 8'd1;
                    end
                end
                S_HIGH: begin
                    if (w_half_end) begin
                        r_half <= 8'd0;
                        r_sclk <= 1'b0;
                        if (r_bit != 3'd7) begin
                            // Shift on the falling edge so data is settled a
                            // full half period before the next rising edge.
                            r_sr    <= {r_sr[6:0], 1'b0};
                            r_bit   <= r_bit + 3'd1;
                            r_state <= S_LOW;
                        end else begin
                            // Clearing the register forces o_mosi low while
                            // the strobe is up and leaves it low in idle.
                            r_sr    <= 8'h00;
                            r_stb   <= 1'b1;
                            r_state <= S_LATCH;
                        end
                    end else begin
                        r_half <= r_half + 8'd1;
                    end
                end
                S_LATCH: begin
                    if (w_half_end) begin
                        r_half  <= 8'd0;
                        r_stb   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_half <= r_half + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_sclk = r_sclk;
    assign bus.o_mosi = r_sr[7];
    assign bus.o_stb  = r_stb;
    assign bus.o_busy = r_busy;
    assign bus.o_done = r_done;

endmodule
`default_nettype wire
